// File: rtl/fp32_vec8_feeder_if.sv
// fp32_vec8_feeder_if
//   Stream bundle for fp32_vec8_feeder.
//   Element side: in_valid/in_ready handshake carrying in_data, in_last and in_dtz.
//   Result side:  out_valid/out_ready handshake carrying out_sum, out_nan,
//                 out_inf and out_count.
//   master: the environment, which drives elements and consumes results.
//   slave : the feeder.
interface fp32_vec8_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_dtz;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_nan;
  logic        out_inf;
  logic [3:0]  out_count;

  modport master (
    output in_valid, in_data, in_last, in_dtz, out_ready,
    input  in_ready, out_valid, out_sum, out_nan, out_inf, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, in_dtz, out_ready,
    output in_ready, out_valid, out_sum, out_nan, out_inf, out_count
  );
endinterface

// File: rtl/fp32_vec8_feeder.sv
// fp32_vec8_feeder
//   Collects up to eight FP32 elements into lanes feeding an external
//   8-input combinational adder tree, pads unfilled lanes with PAD_WORD,
//   holds the lanes stable for one ISSUE cycle, registers the tree result
//   and presents it on a valid/ready result port.
// Ports:
//   clk, rst           sole clock, synchronous active-high reset
//   bus (slave)        element stream in, result stream out
//   fp_inputs_flat     lane k at [32k+31:32k], to the adder tree
//   denorm_to_zero_en  in_dtz captured with the first element of the group
//   fp_sum, is_nan_in, is_inf_in  combinational result from the adder tree
//   groups_done        completed-group counter, wraps
module fp32_vec8_feeder #(
  parameter logic [31:0] PAD_WORD = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  fp32_vec8_feeder_if.slave    bus,
  output logic [255:0]         fp_inputs_flat,
  output logic                 denorm_to_zero_en,
  input  logic [31:0]          fp_sum,
  input  logic                 is_nan_in,
  input  logic                 is_inf_in,
  output logic [15:0]          groups_done
);

  typedef enum logic [1:0] {COLLECT, ISSUE, HOLD} state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [7:0][31:0] lanes;
  logic             dtz_q;
  logic             out_valid_q;
  logic [31:0]      out_sum_q;
  logic             out_nan_q;
  logic             out_inf_q;
  logic [3:0]       out_count_q;
  logic [15:0]      groups_q;
  logic             accept;

  // in_ready is forced low while reset is asserted so nothing is accepted
  // in the reset cycle even though state may already read COLLECT.
  assign bus.in_ready = (state == COLLECT) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      cnt         <= '0;
      lanes       <= {8{PAD_WORD}};
      dtz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_nan_q   <= 1'b0;
      out_inf_q   <= 1'b0;
      out_count_q <= '0;
      groups_q    <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            lanes[cnt] <= bus.in_data;
            if (cnt == 3'd0) dtz_q <= bus.in_dtz;
            if (bus.in_last || (cnt == 3'd7)) begin
              // Lanes above the current one get the pad word on the same
              // edge; with cnt==7 the loop selects nothing.
              for (int unsigned k = 0; k < 8; k++) begin
                if (k > 32'(cnt)) lanes[k[2:0]] <= PAD_WORD;
              end
              out_count_q <= {1'b0, cnt} + 4'd1;
              state       <= ISSUE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        ISSUE: begin
          out_sum_q   <= fp_sum;
          out_nan_q   <= is_nan_in;
          out_inf_q   <= is_inf_in;
          groups_q    <= groups_q + 16'd1;
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            cnt         <= '0;
            state       <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign fp_inputs_flat    = lanes;
  assign denorm_to_zero_en = dtz_q;
  assign groups_done       = groups_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_sum       = out_sum_q;
  assign bus.out_nan       = out_nan_q;
  assign bus.out_inf       = out_inf_q;
  assign bus.out_count     = out_count_q;

endmodule

// File: doc/fp32_vec8_feeder.md
FP32_VEC8_FEEDER -- requirements
Module: fp32_vec8_feeder

Interface
REQ-001 Parameter PAD_WORD, default 32'h8000_0000 (-0.0), FP32 word placed in unfilled lanes of a partial group.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  upstream element valid.
REQ-006 in_ready  out  1  feeder accepts element this cycle.
REQ-007 in_data  in  32  FP32 element.
REQ-008 in_last  in  1  element closes the current group; pad remaining lanes.
REQ-009 in_dtz  in  1  denorm-to-zero request, captured with the first element of each group.
REQ-010 fp_inputs_flat  out  256  lane k at bits [32k+31:32k], drives the 8-input adder tree.
REQ-011 denorm_to_zero_en  out  1  captured in_dtz for the group in flight.
REQ-012 fp_sum  in  32  combinational sum returned by the adder tree.
REQ-013 is_nan_in  in  1  tree NaN flag.
REQ-014 is_inf_in  in  1  tree Inf flag.
REQ-015 out_valid  out  1  result held for downstream.
REQ-016 out_ready  in  1  downstream accepts result.
REQ-017 out_sum  out  32  registered group sum.
REQ-018 out_nan  out  1  registered NaN flag.
REQ-019 out_inf  out  1  registered Inf flag.
REQ-020 out_count  out  4  real elements in the group, 1..8.
REQ-021 groups_done  out  16  completed-group counter; wraps 0xFFFF->0.

Function
REQ-022 States: COLLECT, ISSUE, HOLD; reset state COLLECT.
REQ-023 COLLECT: in_ready=1; a handshake (in_valid&in_ready) writes in_data into lane[cnt] and increments cnt.
REQ-024 First element of a group (cnt=0) also captures in_dtz into the denorm_to_zero_en register.
REQ-025 COLLECT->ISSUE on the handshake that fills lane 7, or on any handshake with in_last=1.
REQ-026 On in_last with cnt<7, lanes cnt+1..7 load PAD_WORD in the same edge; out_count is set to cnt+1.
REQ-027 in_last on the 8th element: no padding; out_count=8.
REQ-028 ISSUE, exactly one cycle: in_ready=0; fp_inputs_flat and denorm_to_zero_en stay stable from registers.
REQ-029 At the end of the ISSUE cycle, fp_sum, is_nan_in and is_inf_in are registered into out_sum, out_nan and out_inf; groups_done increments; the next state is HOLD.
REQ-030 HOLD: out_valid=1; in_ready=0; out_sum, out_nan, out_inf and out_count are held stable until out_ready=1.
REQ-031 HOLD with out_ready=1: next cycle out_valid=0, cnt=0, state COLLECT.
REQ-032 fp_inputs_flat changes only on a COLLECT handshake; lanes are not cleared between groups, and stale lanes are always overwritten before ISSUE.
REQ-033 Pad value -0.0 is sum-neutral: the group sum is not changed, including the sign of zero.
REQ-034 Minimum period per group is N accept cycles + 1 ISSUE cycle + 1 HOLD cycle. Latency from the last accept to out_valid is 2 cycles.
REQ-035 in_data is ignored when in_ready=0; in_valid is allowed to stay high across ISSUE and HOLD without loss.

Reset
REQ-036 rst=1 at a clock edge: state=COLLECT, cnt=0, out_valid=0, out_sum=0, out_nan=0, out_inf=0, out_count=0, groups_done=0, denorm_to_zero_en=0, all lanes=PAD_WORD.
REQ-037 Reset takes priority over all handshakes. A partial group or held result present at reset is discarded and never emitted.
REQ-038 in_ready is 0 during the reset cycle and 1 in the first cycle after reset release.

Verification
REQ-039 Eight 0x3F800000 with in_last on the 8th -> out_sum=0x41000000, out_count=8, out_nan=0, out_inf=0, out_valid 2 cycles after the last accept.
REQ-040 Elements 0x3F800000, 0x40000000, 0xBF000000 with in_last on the 3rd -> lanes 3..7=0x80000000, out_sum=0x40200000, out_count=3.
REQ-041 Single 0x80000000 with in_last -> out_sum=0x80000000, out_count=1. Single 0x00000000 with in_last -> out_sum=0x00000000.
REQ-042 0x7F800000 and 0xFF800000 with in_last -> out_nan=1, out_inf=0, out_count=2.
REQ-043 out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> out_* stable, in_ready=0, no element consumed; groups_done increments exactly once per group.
REQ-044 rst asserted after 5 accepts -> next group of 8 x 0x3F800000 gives out_sum=0x41000000, out_count=8, groups_done=1.
